// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: decodes transactions into an ID/scratch/error
// counter, a RW configuration array and a sampled RO status window.
module spi_reg_bank #(
  parameter int                 ADDRSZ    = 7,
  parameter int                 PAYLOAD   = 8,
  parameter int                 NCFG      = 16,
  parameter logic [ADDRSZ-1:0]  CFG_BASE  = 7'h10,
  parameter int                 NSTAT     = 8,
  parameter logic [ADDRSZ-1:0]  STAT_BASE = 7'h60,
  parameter logic [PAYLOAD-1:0] ID_VALUE  = 8'hA5,
  parameter logic [PAYLOAD-1:0] CFG_RESET = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_start_flag,
  input  logic [ADDRSZ-1:0]        reg_addr,
  input  logic                     addr_valid,
  input  logic                     rw_out,
  input  logic [PAYLOAD-1:0]       wr_data,
  input  logic                     wr_data_valid,
  output logic [PAYLOAD-1:0]       read_data,
  output logic                     read_en,
  input  logic [NSTAT*PAYLOAD-1:0] status_in,
  output logic [NCFG*PAYLOAD-1:0]  cfg_regs,
  output logic                     cfg_wr_stb,
  output logic [ADDRSZ-1:0]        cfg_wr_addr,
  output logic [7:0]               err_cnt,
  output logic [1:0]               fsm_state_o
);

  // Handshake: there is no ready; the slave's addr_valid is a level framing the
  // transaction, wr_data_valid's rising edge marks the payload, and read_en/read_data
  // stay valid for the whole read so the slave can sample them at any later cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RD_HOLD = 2'd1, WR_WAIT = 2'd2, WR_DONE = 2'd3} state_t;

  localparam int CIW     = (NCFG  > 1) ? $clog2(NCFG)  : 1;
  localparam int SIW     = (NSTAT > 1) ? $clog2(NSTAT) : 1;
  localparam int CFG_END  = int'(CFG_BASE) + NCFG;
  localparam int STAT_END = int'(STAT_BASE) + NSTAT;
  localparam logic [ADDRSZ-1:0] A_ID      = ADDRSZ'(0);
  localparam logic [ADDRSZ-1:0] A_SCRATCH = ADDRSZ'(1);
  localparam logic [ADDRSZ-1:0] A_ERR     = ADDRSZ'(2);

  function automatic logic is_cfg(input logic [ADDRSZ-1:0] a);
    return (int'(a) >= int'(CFG_BASE)) && (int'(a) < CFG_END);
  endfunction

  function automatic logic is_stat(input logic [ADDRSZ-1:0] a);
    return (int'(a) >= int'(STAT_BASE)) && (int'(a) < STAT_END);
  endfunction

  state_t               state_q, state_d;
  logic                 av_q, wdv_q;
  logic [ADDRSZ-1:0]    addr_q, addr_d;
  logic [PAYLOAD-1:0]   rdata_q, rdata_d;
  logic                 ren_q, ren_d;
  logic                 stb_q, stb_d;
  logic [ADDRSZ-1:0]    waddr_q, waddr_d;
  logic [7:0]           err_q, err_d;
  logic [PAYLOAD-1:0]   scratch_q, scratch_d;
  logic [PAYLOAD-1:0]   cfg_q [NCFG];
  logic [PAYLOAD-1:0]   cfg_d [NCFG];
  logic [PAYLOAD-1:0]   stat_w [NSTAT];
  logic [PAYLOAD-1:0]   rd_mux;
  logic [CIW-1:0]       rd_cidx, wr_cidx;
  logic [SIW-1:0]       rd_sidx;
  logic                 av_rise, wdv_rise;

  assign av_rise  = addr_valid & ~av_q;
  assign wdv_rise = wr_data_valid & ~wdv_q;
  assign rd_cidx  = CIW'(reg_addr - CFG_BASE);
  assign rd_sidx  = SIW'(reg_addr - STAT_BASE);
  assign wr_cidx  = CIW'(addr_q - CFG_BASE);

  always_comb begin
    for (int k = 0; k < NSTAT; k++) stat_w[k] = status_in[k*PAYLOAD +: PAYLOAD];
    for (int k = 0; k < NCFG; k++) cfg_regs[k*PAYLOAD +: PAYLOAD] = cfg_q[k];
  end

  // Status is captured here only at the addr_valid rise, so later status changes
  // never disturb a read already in progress.
  always_comb begin
    rd_mux = '0;
    if (reg_addr == A_ID)           rd_mux = ID_VALUE;
    else if (reg_addr == A_SCRATCH) rd_mux = scratch_q;
    else if (reg_addr == A_ERR)     rd_mux = PAYLOAD'(err_q);
    else if (is_cfg(reg_addr))      rd_mux = cfg_q[rd_cidx];
    else if (is_stat(reg_addr))     rd_mux = stat_w[rd_sidx];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    ren_d     = ren_q;
    stb_d     = 1'b0;
    waddr_d   = waddr_q;
    err_d     = err_q;
    scratch_d = scratch_q;
    for (int k = 0; k < NCFG; k++) cfg_d[k] = cfg_q[k];
    if (spi_start_flag) begin
      state_d = IDLE;
      ren_d   = 1'b0;
      rdata_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (av_rise) begin
            addr_d = reg_addr;
            if (rw_out) begin
              rdata_d = rd_mux;
              ren_d   = 1'b1;
              state_d = RD_HOLD;
            end else begin
              state_d = WR_WAIT;
            end
          end
        end
        RD_HOLD: begin
          if (!addr_valid) begin
            rdata_d = '0;
            ren_d   = 1'b0;
            state_d = IDLE;
          end
        end
        WR_WAIT: begin
          if (wdv_rise) begin
            state_d = WR_DONE;
            if (addr_q == A_SCRATCH) begin
              scratch_d = wr_data;
              stb_d     = 1'b1;
              waddr_d   = addr_q;
            end else if (addr_q == A_ERR) begin
              err_d = '0;
            end else if (is_cfg(addr_q)) begin
              cfg_d[wr_cidx] = wr_data;
              stb_d          = 1'b1;
              waddr_d        = addr_q;
            end else if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end else if (!addr_valid) begin
            state_d = IDLE;
          end
        end
        WR_DONE: begin
          if (!addr_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // Edge trackers follow the pins even in reset, so a level still high when reset
    // releases is not mistaken for a fresh transaction.
    av_q  <= addr_valid;
    wdv_q <= wr_data_valid;
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      ren_q     <= 1'b0;
      stb_q     <= 1'b0;
      waddr_q   <= '0;
      err_q     <= '0;
      scratch_q <= CFG_RESET;
      for (int k = 0; k < NCFG; k++) cfg_q[k] <= CFG_RESET;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      ren_q     <= ren_d;
      stb_q     <= stb_d;
      waddr_q   <= waddr_d;
      err_q     <= err_d;
      scratch_q <= scratch_d;
      for (int k = 0; k < NCFG; k++) cfg_q[k] <= cfg_d[k];
    end
  end

  assign read_data   = rdata_q;
  assign read_en     = ren_q;
  assign cfg_wr_stb  = stb_q;
  assign cfg_wr_addr = waddr_q;
  assign err_cnt     = err_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed vector table, hand-written corner sequences and
// randomized transactions against an address-map reference model.
module tb_spi_reg_bank;

  localparam int NCFG  = 16;
  localparam int NSTAT = 8;

  logic         clk = 1'b0;
  logic         reset, spi_start_flag, addr_valid, rw_out, wr_data_valid;
  logic [6:0]   reg_addr;
  logic [7:0]   wr_data;
  logic [63:0]  status_in;
  logic [7:0]   read_data;
  logic         read_en;
  logic [127:0] cfg_regs;
  logic         cfg_wr_stb;
  logic [6:0]   cfg_wr_addr;
  logic [7:0]   err_cnt;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] cfg_m [NCFG];
  logic [7:0] scratch_m;
  logic [7:0] err_m;

  spi_reg_bank dut (
    .clk(clk), .reset(reset), .spi_start_flag(spi_start_flag),
    .reg_addr(reg_addr), .addr_valid(addr_valid), .rw_out(rw_out),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .read_data(read_data), .read_en(read_en), .status_in(status_in),
    .cfg_regs(cfg_regs), .cfg_wr_stb(cfg_wr_stb), .cfg_wr_addr(cfg_wr_addr),
    .err_cnt(err_cnt), .fsm_state_o(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / model ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) cfg_m[k] = 8'h00;
    scratch_m = 8'h00;
    err_m     = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    int ai = int'(a);
    if (ai == 0) return 8'hA5;
    if (ai == 1) return scratch_m;
    if (ai == 2) return err_m;
    if (ai >= 16 && ai < 16 + NCFG) return cfg_m[ai - 16];
    if (ai >= 96 && ai < 96 + NSTAT) return status_in[(ai - 96)*8 +: 8];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d, output bit stb);
    int ai = int'(a);
    stb = 1'b0;
    if (ai == 1) begin
      scratch_m = d; stb = 1'b1;
    end else if (ai == 2) begin
      err_m = 8'h00;
    end else if (ai >= 16 && ai < 16 + NCFG) begin
      cfg_m[ai - 16] = d; stb = 1'b1;
    end else if (err_m < 8'd255) begin
      err_m = err_m + 8'd1;
    end
  endtask

  function automatic logic [127:0] model_cfg();
    logic [127:0] r;
    for (int k = 0; k < NCFG; k++) r[k*8 +: 8] = cfg_m[k];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
    reg_addr = a; rw_out = 1'b1; addr_valid = 1'b1;
    tick();
    check("rd_en", read_en, 1'b1);
    check("rd_data", read_data, exp);
    tick();
    check("rd_hold", read_data, exp);
    addr_valid = 1'b0; rw_out = 1'b0;
    tick();
    check("rd_en_drop", read_en, 1'b0);
    check("rd_data_drop", read_data, 8'h00);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit exp_stb,
                          input logic [7:0] exp_err);
    reg_addr = a; rw_out = 1'b0; addr_valid = 1'b1;
    tick();
    check("wr_wait_state", fsm_state, 2'd2);
    wr_data = d; wr_data_valid = 1'b1;
    tick();
    check("wr_stb", cfg_wr_stb, exp_stb);
    check("err_cnt", err_cnt, exp_err);
    if (exp_stb) check("wr_addr", cfg_wr_addr, a);
    tick();
    check("stb_pulse_end", cfg_wr_stb, 1'b0);
    wr_data_valid = 1'b0; addr_valid = 1'b0;
    tick();
    check("wr_idle", fsm_state, 2'd0);
  endtask

  task automatic write_and_check(input logic [6:0] a, input logic [7:0] d);
    bit stb;
    model_write(a, d, stb);
    do_write(a, d, stb, err_m);
    check("cfg_regs", cfg_regs, model_cfg());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    bit         exp_stb;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[24];

  initial begin
    bit stb;
    logic [6:0] ra;
    vecs[0]  = '{1'b0, 7'h00, 8'h00, 8'hA5, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 7'h13, 8'h3C, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 7'h13, 8'h00, 8'h3C, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 7'h00, 8'h55, 8'h00, 1'b0, 8'h01};
    vecs[4]  = '{1'b1, 7'h61, 8'h55, 8'h00, 1'b0, 8'h02};
    vecs[5]  = '{1'b1, 7'h7F, 8'h55, 8'h00, 1'b0, 8'h03};
    vecs[6]  = '{1'b0, 7'h02, 8'h00, 8'h03, 1'b0, 8'h03};
    vecs[7]  = '{1'b1, 7'h02, 8'h55, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 7'h01, 8'h9A, 8'h00, 1'b1, 8'h00};
    vecs[9]  = '{1'b0, 7'h01, 8'h00, 8'h9A, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 7'h1F, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 7'h1F, 8'hE1, 8'h00, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 7'h1F, 8'h00, 8'hE1, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 7'h10, 8'h01, 8'h00, 1'b1, 8'h00};
    vecs[14] = '{1'b0, 7'h10, 8'h00, 8'h01, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 7'h20, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[16] = '{1'b1, 7'h20, 8'h44, 8'h00, 1'b0, 8'h01};
    vecs[17] = '{1'b1, 7'h0F, 8'h44, 8'h00, 1'b0, 8'h02};
    vecs[18] = '{1'b0, 7'h60, 8'h00, 8'hC0, 1'b0, 8'h02};
    vecs[19] = '{1'b0, 7'h67, 8'h00, 8'hC7, 1'b0, 8'h02};
    vecs[20] = '{1'b0, 7'h68, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[21] = '{1'b0, 7'h5F, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[22] = '{1'b0, 7'h7F, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[23] = '{1'b0, 7'h02, 8'h00, 8'h02, 1'b0, 8'h02};

    reset = 1'b0; spi_start_flag = 1'b0; addr_valid = 1'b0; rw_out = 1'b0;
    wr_data_valid = 1'b0; reg_addr = '0; wr_data = '0;
    for (int k = 0; k < NSTAT; k++) status_in[k*8 +: 8] = 8'hC0 | 8'(k);
    model_reset();
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_read_en", read_en, 1'b0);
    check("rst_read_data", read_data, 8'h00);
    check("rst_cfg_regs", cfg_regs, 128'h0);
    check("rst_stb", cfg_wr_stb, 1'b0);
    check("rst_wr_addr", cfg_wr_addr, 7'h00);
    check("rst_err", err_cnt, 8'h00);
    check("rst_state", fsm_state, 2'd0);

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) begin
        model_write(vecs[i].addr, vecs[i].data, stb);
        do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_stb, vecs[i].exp_err);
        check("vec_cfg_regs", cfg_regs, model_cfg());
      end else begin
        do_read(vecs[i].addr, vecs[i].exp_rd);
      end
    end
    check("cfg_reg3_byte", cfg_regs[31:24], 8'h3C);

    // aborted write: addr_valid falls before any payload edge
    reg_addr = 7'h14; rw_out = 1'b0; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    tick();
    check("abort_idle", fsm_state, 2'd0);
    wr_data = 8'hEE; wr_data_valid = 1'b1;
    tick();
    check("abort_no_stb", cfg_wr_stb, 1'b0);
    check("abort_cfg", cfg_regs, model_cfg());
    check("abort_err", err_cnt, err_m);
    wr_data_valid = 1'b0;
    tick();

    // spi_start_flag while holding a read
    reg_addr = 7'h00; rw_out = 1'b1; addr_valid = 1'b1;
    tick();
    check("sf_rd_en", read_en, 1'b1);
    spi_start_flag = 1'b1;
    tick();
    spi_start_flag = 1'b0;
    check("sf_rd_en_clr", read_en, 1'b0);
    check("sf_rd_data_clr", read_data, 8'h00);
    check("sf_state", fsm_state, 2'd0);
    addr_valid = 1'b0; rw_out = 1'b0;
    tick();
    check("sf_state_after", fsm_state, 2'd0);

    // status sampled at the addr_valid rise only
    status_in[7:0] = 8'h11;
    reg_addr = 7'h60; rw_out = 1'b1; addr_valid = 1'b1;
    tick();
    check("stat_sample", read_data, 8'h11);
    status_in[7:0] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stat_hold", read_data, 8'h11);
    end
    addr_valid = 1'b0; rw_out = 1'b0;
    tick();
    check("stat_drop", read_en, 1'b0);

    // second payload edge in WR_DONE is ignored
    reg_addr = 7'h16; rw_out = 1'b0; addr_valid = 1'b1;
    tick();
    wr_data = 8'h77; wr_data_valid = 1'b1;
    tick();
    model_write(7'h16, 8'h77, stb);
    check("done_first_stb", cfg_wr_stb, 1'b1);
    wr_data_valid = 1'b0;
    tick();
    wr_data = 8'h88; wr_data_valid = 1'b1;
    tick();
    check("done_second_stb", cfg_wr_stb, 1'b0);
    check("done_cfg", cfg_regs, model_cfg());
    wr_data_valid = 1'b0; addr_valid = 1'b0;
    tick();
    check("done_idle", fsm_state, 2'd0);

    // error counter saturation and clear
    for (int i = 0; i < 260; i++) write_and_check(7'h7F, 8'(i));
    check("err_sat", err_cnt, 8'hFF);
    do_read(7'h02, 8'hFF);
    write_and_check(7'h02, 8'h00);
    check("err_clear", err_cnt, 8'h00);
    write_and_check(7'h70, 8'h01);
    write_and_check(7'h01, 8'h5B);

    // reset pulse while in WR_WAIT
    reg_addr = 7'h15; rw_out = 1'b0; addr_valid = 1'b1;
    tick();
    check("rw_wr_wait", fsm_state, 2'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wr_data = 8'h5A; wr_data_valid = 1'b1;
    tick();
    model_reset();
    check("rw_cfg", cfg_regs, 128'h0);
    check("rw_stb", cfg_wr_stb, 1'b0);
    check("rw_wr_addr", cfg_wr_addr, 7'h00);
    check("rw_err", err_cnt, 8'h00);
    check("rw_read_en", read_en, 1'b0);
    check("rw_read_data", read_data, 8'h00);
    check("rw_state", fsm_state, 2'd0);
    tick();
    check("rw_stb_late", cfg_wr_stb, 1'b0);
    check("rw_state_late", fsm_state, 2'd0);
    wr_data_valid = 1'b0; addr_valid = 1'b0;
    tick();
    do_read(7'h01, 8'h00);

    // randomized transactions against the model
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 7'($urandom_range(0, 2));
        1: ra = 7'($urandom_range(16, 31));
        2: ra = 7'($urandom_range(96, 103));
        default: ra = 7'($urandom_range(0, 127));
      endcase
      status_in = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        exp_q.push_back(model_read(ra));
        do_read(ra, exp_q.pop_front());
      end else begin
        write_and_check(ra, 8'($urandom_range(0, 255)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
